trace_shim: RTL

Parametrised verification shim around the `top` core, successor to the plain `tb` wrapper. It passes instruction and result traffic through unchanged. It also records a bounded trace of result changes and conditional jumps into an internal FIFO, which the bench drains through a valid/ready port. Free-running cycle and jump counters let the bench check both timing and control flow without post-processing the waveform dump.

---
 rtl/trace_shim.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/trace_shim.sv
// trace_shim -- verification shim around the `top` core.
//
// Passes instruction/result traffic to and from the core unchanged. It also
// records result changes and conditional jumps into a bounded trace FIFO,
// which the bench drains through a valid/ready port. Free-running cycle and
// jump counters expose timing and control flow directly.
//
// Optional feature macro: TRACE_TIMESTAMP_EN
//   defined   : every FIFO entry also stores cyc_cnt at capture; trace_ts
//               presents the stored value of the head entry.
//   undefined : entries are OUT_W+1 bits ({r, cjump}); trace_ts is tied to 0.
//
// Ports (trace_shim):
//   clk          in   1          single clock, rising edge
//   rst          in   1          asynchronous active-low reset (also core reset)
//   instr        in   INSTR_W    instruction to the core (passthrough)
//   r            out  OUT_W      core result (passthrough)
//   cjump        out  1          core conditional-jump flag (passthrough)
//   trace_en     in   1          enables event capture
//   clear        in   1          synchronous flush of FIFO, counters and flags
//   trace_valid  out  1          FIFO head holds a valid entry
//   trace_ready  in   1          consumer accepts the head entry
//   trace_r      out  OUT_W      head entry result value
//   trace_cj     out  1          head entry cjump bit
//   trace_ts     out  TS_W       head entry timestamp
//   cyc_cnt      out  TS_W       cycles since reset/clear (wraps)
//   jmp_cnt      out  CNT_W      cjump cycles since reset/clear (saturates)
//   level        out  clog2(DEPTH+1)  FIFO occupancy
//   overflow     out  1          sticky: an event was dropped
//
// The file also carries the small `top` core that the shim wraps:
//   instr = {op[1:0], imm[INSTR_W-3:0]}
//   op 00 NOP : r holds
//   op 01 LD  : r <= imm (zero-extended / truncated to OUT_W)
//   op 10 ADD : r <= r + imm (modulo 2^OUT_W)
//   op 11 JMP : r holds; cjump = 1 when r != 0 (combinational)

module top #(
  parameter int unsigned INSTR_W = 6,
  parameter int unsigned OUT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  output logic [OUT_W-1:0]   r,
  output logic               cjump
);

  localparam int unsigned IMM_W = INSTR_W - 2;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_LD  = 2'b01,
    OP_ADD = 2'b10,
    OP_JMP = 2'b11
  } op_e;

  op_e              op;
  logic [IMM_W-1:0] imm;
  logic [OUT_W-1:0] imm_ext;

  assign op      = op_e'(instr[INSTR_W-1 -: 2]);
  assign imm     = instr[IMM_W-1:0];
  assign imm_ext = OUT_W'(imm);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
    end else begin
      case (op)
        OP_LD:   r <= imm_ext;
        OP_ADD:  r <= r + imm_ext;
        default: r <= r;
      endcase
    end
  end

  assign cjump = (op == OP_JMP) && (r != '0);

endmodule

module trace_shim #(
  parameter int unsigned INSTR_W = 6,
  parameter int unsigned OUT_W   = 5,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INSTR_W-1:0]         instr,
  output logic [OUT_W-1:0]           r,
  output logic                       cjump,
  input  logic                       trace_en,
  input  logic                       clear,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [OUT_W-1:0]           trace_r,
  output logic                       trace_cj,
  output logic [TS_W-1:0]            trace_ts,
  output logic [TS_W-1:0]            cyc_cnt,
  output logic [CNT_W-1:0]           jmp_cnt,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);
`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned E_W = OUT_W + 1 + TS_W;
`else
  localparam int unsigned E_W = OUT_W + 1;
`endif

  // Core: outputs drive the passthrough ports directly (zero latency).
  top #(
    .INSTR_W (INSTR_W),
    .OUT_W   (OUT_W)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .instr (instr),
    .r     (r),
    .cjump (cjump)
  );

  logic [OUT_W-1:0] r_prev;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [E_W-1:0]   mem [DEPTH];
  logic [E_W-1:0]   wr_entry;
  logic [E_W-1:0]   head;
  logic             event_hit;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign trace_valid = (level != '0);
  assign pop         = trace_valid && trace_ready;
  assign event_hit   = trace_en && ((r != r_prev) || cjump);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok     = event_hit && ((level < LVL_W'(DEPTH)) || pop);
  assign drop        = event_hit && !push_ok;

`ifdef TRACE_TIMESTAMP_EN
  assign wr_entry = {r, cjump, cyc_cnt};
`else
  assign wr_entry = {r, cjump};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      cyc_cnt  <= '0;
      jmp_cnt  <= '0;
    end else if (clear) begin
      r_prev   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      cyc_cnt  <= '0;
      jmp_cnt  <= '0;
    end else begin
      r_prev  <= r;
      cyc_cnt <= cyc_cnt + TS_W'(1);
      if (cjump && (jmp_cnt != '1)) begin
        jmp_cnt <= jmp_cnt + CNT_W'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is only observed while level != 0.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  assign head     = mem[rd_ptr];
  assign trace_r  = trace_valid ? head[E_W-1 -: OUT_W] : '0;
  assign trace_cj = trace_valid && head[E_W-OUT_W-1];

`ifdef TRACE_TIMESTAMP_EN
  assign trace_ts = trace_valid ? head[TS_W-1:0] : '0;
`else
  assign trace_ts = '0;
`endif

endmodule
